// File: rtl/regfile_scoreboard_pkg.sv
// Shared types for the register file / scoreboard slice.
// Holds the default widths and the address, data, read-port and write-back
// bundle types. The top takes its parameter defaults from here.
package regfile_scoreboard_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   addr_t;
    typedef logic [XLEN-1:0] data_t;

    // One read port as seen by a consumer: source address in, data and busy out.
    typedef struct packed {
        addr_t addr;
        data_t data;
        logic  busy;
    } rd_port_t;

    // One write-back strobe with its destination and result.
    typedef struct packed {
        logic  valid;
        addr_t addr;
        data_t data;
    } wb_t;

endpackage

// File: rtl/regfile_scoreboard_pending_counter.sv
// pending_counter: saturating up/down counter of in-flight writes to one register.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   inc, dec, clr : count up, count down, clear (clr wins over inc/dec)
//   count         : current pending count
//   zero, max     : count is 0 / count is all ones
// inc together with dec leaves the count unchanged. The count never wraps
// in either direction.
module pending_counter #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            dec,
    input  logic            clr,
    output logic [CNTW-1:0] count,
    output logic            zero,
    output logic            max
);

    logic [CNTW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)                        count_d = '0;
        else if (inc && !dec && !max)   count_d = count_q + CNTW'(1);
        else if (dec && !inc && !zero)  count_d = count_q - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
    assign max   = (count_q == '1);

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register pending-write counters.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   rd_addr/rd_data/rd_busy      : NREAD combinational read ports with write-back bypass
//   iss_valid/iss_rd/iss_ready   : issue of an instruction that will write iss_rd
//   wb_valid/wb_addr/wb_data     : write-back strobe
//   flush                        : drop every pending write (killed instructions)
// Register 0 is hardwired to zero and carries no counter.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN  = regfile_scoreboard_pkg::XLEN,
    parameter int NREG  = regfile_scoreboard_pkg::NREG,
    parameter int NREAD = 2,
    parameter int CNTW  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREAD-1:0][AW-1:0]   rd_addr,
    output logic [NREAD-1:0][XLEN-1:0] rd_data,
    output logic [NREAD-1:0]           rd_busy,
    input  logic                       iss_valid,
    input  logic [AW-1:0]              iss_rd,
    output logic                       iss_ready,
    input  logic                       wb_valid,
    input  logic [AW-1:0]              wb_addr,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       flush
);

    logic [XLEN-1:0] regs_q   [NREG];
    logic [CNTW-1:0] cnt      [NREG];
    logic            cnt_zero [NREG];
    logic            cnt_max  [NREG];

    // Register 0 never has writes in flight.
    assign cnt[0]      = '0;
    assign cnt_zero[0] = 1'b1;
    assign cnt_max[0]  = 1'b0;

    // Only the counter state gates issue; a same-cycle write-back does not
    // free a slot early.
    assign iss_ready = !cnt_max[iss_rd];

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        pending_counter #(.CNTW(CNTW)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (iss_valid && iss_ready && (iss_rd == AW'(r))),
            .dec   (wb_valid && (wb_addr == AW'(r))),
            .clr   (flush),
            .count (cnt[r]),
            .zero  (cnt_zero[r]),
            .max   (cnt_max[r])
        );
    end

    // Storage: every entry cleared on reset; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else if (wb_valid && wb_addr != '0) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic wb_hit;
        assign wb_hit     = wb_valid && (wb_addr == rd_addr[i]) && (rd_addr[i] != '0);
        assign rd_data[i] = wb_hit ? wb_data : regs_q[rd_addr[i]];
        // The last outstanding write landing this cycle satisfies the read.
        assign rd_busy[i] = !cnt_zero[rd_addr[i]] &&
                            !(wb_hit && cnt[rd_addr[i]] == CNTW'(1));
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic             iss_valid;
    logic [4:0]       iss_rd;
    logic             iss_ready;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             flush;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;
    exp_t sb[$];

    logic [31:0] model [32];

    regfile_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // Advance one edge and return 2 time units after it, inputs back to idle.
    task automatic step();
        @(posedge clk);
        #2;
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic push(input string tag, input int port, input logic [31:0] d, input logic b);
        exp_t e;
        e.tag = tag; e.port = port; e.data = d; e.busy = b;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1; iss_valid = 1'b1; iss_rd = 5'd2; wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h1234;
        step();
        foreach (model[r]) model[r] = '0;
        for (int k = 0; k < 4; k++) begin
            logic [4:0] a;
            a = (k == 3) ? 5'd31 : 5'(k * 2);
            rd_addr[0] = a; rd_addr[1] = a; iss_rd = a;
            push("reset", 0, 32'h0, 1'b0);
            push("reset", 1, 32'h0, 1'b0);
            #1;
            while (sb.size() != 0) begin
                exp_t e = sb.pop_front();
                vectors++;
                if (rd_data[e.port] !== e.data || rd_busy[e.port] !== e.busy) begin
                    errors++;
                    $display("FAIL %s addr %0d port %0d: got data %h busy %b, want %h %b",
                             e.tag, a, e.port, rd_data[e.port], rd_busy[e.port], e.data, e.busy);
                end
            end
            vectors++;
            if (iss_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready addr %0d: got %b want 1", a, iss_ready);
            end
        end
    endtask

    task automatic test_wb_bypass();
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        push("bypass", 0, 32'hDEADBEEF, 1'b0);
        #1;
        begin
            exp_t e = sb.pop_front(); vectors++;
            if (rd_data[0] !== e.data || rd_busy[0] !== e.busy) begin
                errors++;
                $display("FAIL %s: got %h/%b want %h/%b", e.tag, rd_data[0], rd_busy[0], e.data, e.busy);
            end
        end
        step();
        model[5] = 32'hDEADBEEF;
        push("stored", 1, model[5], 1'b0);
        #1;
        begin
            exp_t e = sb.pop_front(); vectors++;
            if (rd_data[1] !== e.data || rd_busy[1] !== e.busy) begin
                errors++;
                $display("FAIL %s: got %h/%b want %h/%b", e.tag, rd_data[1], rd_busy[1], e.data, e.busy);
            end
        end
    endtask

    task automatic test_saturate();
        rd_addr[0] = 5'd7;
        for (int k = 0; k < 4; k++) begin
            iss_valid = 1'b1; iss_rd = 5'd7;
            #1; vectors++;
            if (iss_ready !== (k < 3)) begin
                errors++;
                $display("FAIL sat_ready issue %0d: got %b want %b", k, iss_ready, k < 3);
            end
            step();
        end
        // Three write-backs; busy must drop exactly on the third.
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'(32'h700 + k); iss_rd = 5'd7;
            push("sat_wb", 0, 32'(32'h700 + k), (k < 2));
            #1;
            begin
                exp_t e = sb.pop_front(); vectors++;
                if (rd_data[0] !== e.data || rd_busy[0] !== e.busy) begin
                    errors++;
                    $display("FAIL %s %0d: got %h/%b want %h/%b", e.tag, k, rd_data[0], rd_busy[0], e.data, e.busy);
                end
            end
            if (k == 0) begin
                // Counter at max: a same-cycle write-back must not raise ready.
                vectors++;
                if (iss_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_ready_wb: got %b want 0", iss_ready);
                end
            end
            step();
        end
        model[7] = 32'h702;
        push("sat_after", 0, model[7], 1'b0);
        #1;
        begin
            exp_t e = sb.pop_front(); vectors++;
            if (rd_data[0] !== e.data || rd_busy[0] !== e.busy || iss_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s: got %h/%b rdy %b want %h/%b rdy 1", e.tag, rd_data[0], rd_busy[0], iss_ready, e.data, e.busy);
            end
        end
    endtask

    task automatic test_issue_wb_same();
        rd_addr[0] = 5'd3;
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        iss_valid = 1'b1; iss_rd = 5'd3; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        step();
        model[3] = 32'h11;
        push("iss_wb_same", 0, model[3], 1'b1);
        #1;
        begin
            exp_t e = sb.pop_front(); vectors++;
            if (rd_data[0] !== e.data || rd_busy[0] !== e.busy) begin
                errors++;
                $display("FAIL %s: got %h/%b want %h/%b", e.tag, rd_data[0], rd_busy[0], e.data, e.busy);
            end
        end
        // Drain the remaining pending write; count must have been exactly 1.
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        step();
        push("iss_wb_drain", 0, model[3], 1'b0);
        #1;
        begin
            exp_t e = sb.pop_front(); vectors++;
            if (rd_data[0] !== e.data || rd_busy[0] !== e.busy) begin
                errors++;
                $display("FAIL %s: got %h/%b want %h/%b", e.tag, rd_data[0], rd_busy[0], e.data, e.busy);
            end
        end
    endtask

    task automatic test_flush();
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd4; step();
        iss_valid = 1'b1; iss_rd = 5'd9; step();
        #1; vectors++;
        if (rd_busy !== 2'b11) begin
            errors++;
            $display("FAIL flush_pre busy: got %b want 11", rd_busy);
        end
        // Flush beats a same-cycle issue.
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
        step();
        #1; vectors++;
        if (rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL flush_post busy: got %b want 00", rd_busy);
        end
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h22;
        step();
        model[4] = 32'h22;
        // One issue after the stray write-back: a single write-back must clear it.
        iss_valid = 1'b1; iss_rd = 5'd4;
        step();
        push("flush_wb", 0, model[4], 1'b1);
        #1;
        begin
            exp_t e = sb.pop_front(); vectors++;
            if (rd_data[0] !== e.data || rd_busy[0] !== e.busy) begin
                errors++;
                $display("FAIL %s: got %h/%b want %h/%b", e.tag, rd_data[0], rd_busy[0], e.data, e.busy);
            end
        end
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h22;
        step();
        #1; vectors++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_cnt0 busy: got %b want 0", rd_busy[0]);
        end
    endtask

    task automatic test_x0();
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
        for (int c = 0; c < 2; c++) begin
            iss_valid = 1'b1; iss_rd = 5'd0; wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
            push("x0", 0, 32'h0, 1'b0);
            push("x0", 1, 32'h0, 1'b0);
            #1;
            while (sb.size() != 0) begin
                exp_t e = sb.pop_front(); vectors++;
                if (rd_data[e.port] !== e.data || rd_busy[e.port] !== e.busy) begin
                    errors++;
                    $display("FAIL %s cyc %0d port %0d: got %h/%b want %h/%b",
                             e.tag, c, e.port, rd_data[e.port], rd_busy[e.port], e.data, e.busy);
                end
            end
            vectors++;
            if (iss_ready !== 1'b1) begin
                errors++;
                $display("FAIL x0_ready cyc %0d: got %b want 1", c, iss_ready);
            end
            step();
        end
    endtask

    task automatic test_reset_pending();
        rd_addr[0] = 5'd6; rd_addr[1] = 5'd5;
        iss_valid = 1'b1; iss_rd = 5'd6; step();
        #1; vectors++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pend pre busy: got %b want 1", rd_busy[0]);
        end
        reset = 1'b1; wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
        step();
        foreach (model[r]) model[r] = '0;
        iss_rd = 5'd6;
        push("rst_pend", 0, 32'h0, 1'b0);
        push("rst_pend", 1, 32'h0, 1'b0);
        #1;
        while (sb.size() != 0) begin
            exp_t e = sb.pop_front(); vectors++;
            if (rd_data[e.port] !== e.data || rd_busy[e.port] !== e.busy || iss_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s port %0d: got %h/%b rdy %b want %h/%b rdy 1",
                         e.tag, e.port, rd_data[e.port], rd_busy[e.port], iss_ready, e.data, e.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 24; c++) begin
            logic [4:0]  wa, ra;
            logic [31:0] wd;
            wa = 5'($urandom_range(1, 31));
            ra = 5'($urandom_range(0, 31));
            wd = $urandom;
            wb_valid = 1'b1; wb_addr = wa; wb_data = wd;
            rd_addr[0] = wa; rd_addr[1] = ra;
            push("b2b", 0, wd, 1'b0);
            push("b2b", 1, (ra == wa) ? wd : model[ra], 1'b0);
            #1;
            while (sb.size() != 0) begin
                exp_t e = sb.pop_front(); vectors++;
                if (rd_data[e.port] !== e.data || rd_busy[e.port] !== e.busy) begin
                    errors++;
                    $display("FAIL %s cyc %0d port %0d: got %h/%b want %h/%b",
                             e.tag, c, e.port, rd_data[e.port], rd_busy[e.port], e.data, e.busy);
                end
            end
            model[wa] = wd;
            step();
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_rd = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        test_reset();
        test_wb_bypass();
        test_saturate();
        test_issue_wb_same();
        test_flush();
        test_x0();
        test_reset_pending();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter NREG, default 32, number of architectural registers; AW = clog2(NREG).
REQ-003 Parameter NREAD, default 2, number of read ports.
REQ-004 Parameter CNTW, default 2, width of the per-register pending counter; MAXP = 2**CNTW-1.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port rd_addr  input  NREAD x AW  read-port source register addresses.
REQ-008 Port rd_data  output  NREAD x XLEN  read data, including the write-back bypass.
REQ-009 Port rd_busy  output  NREAD  source has a pending write that is not satisfied this cycle.
REQ-010 Port iss_valid  input  1  an instruction writing iss_rd issues this cycle.
REQ-011 Port iss_rd  input  AW  destination of the issuing instruction.
REQ-012 Port iss_ready  output  1  issue accepted; low when the iss_rd counter equals MAXP.
REQ-013 Port wb_valid  input  1  write-back strobe.
REQ-014 Port wb_addr  input  AW  write-back destination.
REQ-015 Port wb_data  input  XLEN  write-back data.
REQ-016 Port flush  input  1  clears every pending counter; killed instructions never write back.

Function
REQ-017 Register 0 reads as 0, is never busy, ignores writes, and ignores issues; iss_ready stays high for iss_rd=0.
REQ-018 Reads are combinational. rd_data = wb_data when wb_valid and wb_addr==rd_addr!=0; otherwise the stored value.
REQ-019 rd_busy[i] = (cnt[rd_addr[i]]!=0), except it is 0 when cnt==1 and the same-cycle write-back hits that address.
REQ-020 Issue is counted only when iss_valid and iss_ready are both high; cnt[iss_rd] increments at the next edge.
REQ-021 A write-back with cnt[wb_addr]!=0 decrements the counter; with cnt==0 it writes data and leaves the counter at 0 (no underflow).
REQ-022 When a counted issue and a write-back hit the same register in one cycle, the counter is unchanged and the data is written.
REQ-023 flush zeroes all counters at the next edge and takes priority over a same-cycle issue. The same-cycle write-back data is still written.
REQ-024 A write-back always updates the storage one cycle after the strobe; latency from wb_valid to a stored read is 1 cycle, with 0 cycles visible through the bypass.
REQ-025 iss_ready is combinational from iss_rd and the counter state only. It does not depend on a same-cycle write-back.
REQ-026 Independent read ports may address the same register and return identical data and busy values.

Reset
REQ-027 When reset is high at an edge, all registers go to 0 and all counters go to 0. Issue, write-back and flush in that cycle are ignored.
REQ-028 After reset: rd_data=0, rd_busy=0 and iss_ready=1 for every address.

Structure
REQ-029 A shared package holds the address and data typedefs, the read-port bundle struct, and the write-back bundle struct, all parametrised through package localparams XLEN=32 and NREG=32.
REQ-030 The per-register saturating up/down counter is a sub-module named pending_counter, with inputs inc, dec and clr, and outputs count, zero and max. It is instantiated NREG-1 times; register 0 has no counter.
REQ-031 The storage array contains no reset-free inference tricks; every entry is reset explicitly.

Verification
REQ-032 Reset, then wb x5=0xDEADBEEF, then read x5 the next cycle -> rd_data=0xDEADBEEF, rd_busy=0. In the write-back cycle the bypass already shows 0xDEADBEEF.
REQ-033 Issue x7 three times (CNTW=2) -> iss_ready=0 for x7 and a fourth issue is not counted. Three write-backs to x7 -> busy clears exactly in the cycle of the third write-back.
REQ-034 Issue x3, then in one cycle issue x3 and wb x3=0x11 -> counter stays 1, rd_busy=1, and stored data is 0x11.
REQ-035 Issue x4 and x9, then flush -> both not busy next cycle. A later wb x4=0x22 writes 0x22 and the counter remains 0.
REQ-036 Issue x0, wb x0=0xFF, read x0 on both ports -> rd_data=0, rd_busy=0, iss_ready=1.
REQ-037 Issue x6, then assert reset while x6 is pending -> after reset x6 reads 0, is not busy, and iss_ready=1.
